// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader.
//   state_t        : loader FSM states
//   MAX_WORDS      : capacity of the instruction memory in words
//   BYTES_PER_WORD : stream bytes assembled into one instruction word
package imem_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEADER,
        ST_COLLECT,
        ST_WRITE,
        ST_RUN,
        ST_ERROR
    } state_t;

    localparam int MAX_WORDS      = 64;
    localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Big-endian word assembler: shifts accepted bytes in MSB-first and flags
// the byte that completes a word.
// Ports:
//   reloj      in   clock (rising edge)
//   reset      in   synchronous active-low reset
//   clear      in   discard any partial word (restart / timeout)
//   byte_valid in   byte_in is accepted this cycle
//   byte_in    in   stream byte
//   word       out  assembled word (first byte in bits DATA_W-1:DATA_W-8)
//   word_ready out  high in the cycle whose byte completes a word
module word_assembler
    import imem_loader_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              reloj,
    input  logic              reset,
    input  logic              clear,
    input  logic              byte_valid,
    input  logic [7:0]        byte_in,
    output logic [DATA_W-1:0] word,
    output logic              word_ready
);

    logic [DATA_W-1:0] word_reg;
    logic [1:0]        byte_cnt_reg;

    always_ff @(posedge reloj) begin
        if (!reset) begin
            word_reg     <= '0;
            byte_cnt_reg <= '0;
        end else if (clear) begin
            word_reg     <= '0;
            byte_cnt_reg <= '0;
        end else if (byte_valid) begin
            word_reg     <= {word_reg[DATA_W-9:0], byte_in};
            // Two-bit counter wraps naturally after the last byte of a word.
            byte_cnt_reg <= byte_cnt_reg + 2'd1;
        end
    end

    assign word       = word_reg;
    assign word_ready = byte_valid && !clear &&
                        (byte_cnt_reg == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Boot-time loader for the 64-word instruction memory. Receives a byte
// stream (header byte N = word count, then N big-endian words), writes each
// word to the memory write port and releases the core only after a
// complete, valid load.
// Ports:
//   reloj        in   clock (rising edge)
//   reset        in   synchronous active-low reset
//   start        in   one-cycle pulse starting a load (IDLE/RUN/ERROR only)
//   rx_byte      in   stream byte
//   rx_valid     in   rx_byte valid
//   rx_ready     out  loader accepts a byte this cycle
//   imem_we      out  instruction memory write strobe
//   imem_addr    out  word address being written
//   imem_di      out  word being written
//   cpu_resetM   out  active-low core reset (1 only after a good load)
//   busy         out  load in progress
//   done         out  last load succeeded
//   error        out  last load aborted
//   words_loaded out  words written in current/last load
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W      = 6,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic              reloj,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        rx_byte,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_di,
    output logic              cpu_resetM,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [6:0]        words_loaded
);

    localparam int TO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    state_t            state_reg, state_next;
    logic [6:0]        n_reg, n_next;
    logic [6:0]        words_reg, words_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [TO_W-1:0]   to_cnt_reg, to_cnt_next;

    logic xfer;
    logic asm_clear;
    logic asm_valid;
    logic word_ready;
    logic timeout_hit;

    // Handshake and status are pure functions of the current state, which
    // keeps rx_ready free of any dependency on rx_valid.
    assign rx_ready   = (state_reg == ST_HEADER) || (state_reg == ST_COLLECT);
    assign busy       = (state_reg == ST_HEADER) || (state_reg == ST_COLLECT) ||
                        (state_reg == ST_WRITE);
    assign imem_we    = (state_reg == ST_WRITE);
    assign cpu_resetM = (state_reg == ST_RUN);
    assign done       = (state_reg == ST_RUN);
    assign error      = (state_reg == ST_ERROR);

    assign imem_addr    = addr_reg;
    assign words_loaded = words_reg;

    assign xfer        = rx_valid && rx_ready;
    assign asm_valid   = xfer && (state_reg == ST_COLLECT);
    assign timeout_hit = (to_cnt_reg == TO_W'(TIMEOUT_CYC - 1));

    word_assembler #(
        .DATA_W (DATA_W)
    ) u_asm (
        .reloj      (reloj),
        .reset      (reset),
        .clear      (asm_clear),
        .byte_valid (asm_valid),
        .byte_in    (rx_byte),
        .word       (imem_di),
        .word_ready (word_ready)
    );

    always_ff @(posedge reloj) begin
        if (!reset) begin
            state_reg  <= ST_IDLE;
            n_reg      <= '0;
            words_reg  <= '0;
            addr_reg   <= '0;
            to_cnt_reg <= '0;
        end else begin
            state_reg  <= state_next;
            n_reg      <= n_next;
            words_reg  <= words_next;
            addr_reg   <= addr_next;
            to_cnt_reg <= to_cnt_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        n_next      = n_reg;
        words_next  = words_reg;
        addr_next   = addr_reg;
        to_cnt_next = to_cnt_reg;
        asm_clear   = 1'b0;

        case (state_reg)
            ST_IDLE, ST_RUN, ST_ERROR: begin
                if (start) begin
                    state_next  = ST_HEADER;
                    words_next  = '0;
                    addr_next   = '0;
                    to_cnt_next = '0;
                    asm_clear   = 1'b1;
                end
            end

            ST_HEADER: begin
                if (xfer) begin
                    to_cnt_next = '0;
                    if ((rx_byte != 8'd0) && (rx_byte <= 8'(MAX_WORDS))) begin
                        n_next     = rx_byte[6:0];
                        state_next = ST_COLLECT;
                    end else begin
                        state_next = ST_ERROR;
                    end
                end else if (timeout_hit) begin
                    state_next = ST_ERROR;
                end else begin
                    to_cnt_next = to_cnt_reg + 1'b1;
                end
            end

            ST_COLLECT: begin
                if (xfer) begin
                    to_cnt_next = '0;
                    if (word_ready) begin
                        state_next = ST_WRITE;
                    end
                end else if (timeout_hit) begin
                    // Drop the half-built word so a restart begins clean.
                    state_next = ST_ERROR;
                    asm_clear  = 1'b1;
                end else begin
                    to_cnt_next = to_cnt_reg + 1'b1;
                end
            end

            ST_WRITE: begin
                words_next = 7'(words_reg + 7'd1);
                if (7'(words_reg + 7'd1) == n_reg) begin
                    // Address is left on the last word written, so a full
                    // 64-word load never wraps back to 0.
                    state_next = ST_RUN;
                end else begin
                    addr_next  = addr_reg + 1'b1;
                    state_next = ST_COLLECT;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

    localparam int T = 100;

    logic        reloj = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  rx_byte = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        imem_we;
    logic [5:0]  imem_addr;
    logic [31:0] imem_di;
    logic        cpu_resetM;
    logic        busy;
    logic        done;
    logic        error;
    logic [6:0]  words_loaded;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [64];
    int wr_cnt = 0;
    int xfer_cnt = 0;

    imem_loader #(
        .ADDR_W      (6),
        .DATA_W      (32),
        .TIMEOUT_CYC (T)
    ) dut (
        .reloj        (reloj),
        .reset        (reset),
        .start        (start),
        .rx_byte      (rx_byte),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_di      (imem_di),
        .cpu_resetM   (cpu_resetM),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 reloj = ~reloj;

    // Instruction memory model and transfer counter.
    always @(posedge reloj) begin
        if (imem_we) begin
            mem[imem_addr] <= imem_di;
            wr_cnt <= wr_cnt + 1;
            $display("WR   addr=%0d data=%08h", imem_addr, imem_di);
        end
        if (rx_valid && rx_ready) xfer_cnt <= xfer_cnt + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] word_of(input int i);
        return {8'(i), 8'(i ^ 8'h5A), 8'(255 - i), 8'(i + 8'h30)};
    endfunction

    task automatic tick();
        @(posedge reloj);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Present a byte and hold it until accepted; returns just after the
    // accepting edge with rx_valid still high.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        rx_byte  = b;
        rx_valid = 1'b1;
        while (!rx_ready && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (!rx_ready) begin
            errors++;
            $display("FAIL send_byte accept got rx_ready=%b req 1 byte=%02h", rx_ready, b);
        end else begin
            tick();
        end
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int b = 3; b >= 0; b--) send_byte(w[b*8 +: 8]);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) tick();
        checks++;
        if ({rx_ready, imem_we, imem_addr, imem_di} !== 40'd0) begin
            errors++;
            $display("FAIL reset_datapath got %b %b %h %h req zero", rx_ready, imem_we, imem_addr, imem_di);
        end
        checks++;
        if ({cpu_resetM, busy, done, error, words_loaded} !== 11'd0) begin
            errors++;
            $display("FAIL reset_status got %b%b%b%b %0d req zero", cpu_resetM, busy, done, error, words_loaded);
        end
        reset = 1'b1;
        repeat (5) tick();
        checks++;
        if ({rx_ready, busy, cpu_resetM} !== 3'b000) begin
            errors++;
            $display("FAIL reset_idle got rdy=%b busy=%b cpu=%b req 000", rx_ready, busy, cpu_resetM);
        end
        $display("TXN  reset done");
    endtask

    task automatic test_two_word();
        int w0, x0;
        w0 = wr_cnt;
        x0 = xfer_cnt;
        pulse_start();
        checks++;
        if (busy !== 1'b1 || rx_ready !== 1'b1) begin
            errors++;
            $display("FAIL two_hdr got busy=%b rdy=%b req 1 1", busy, rx_ready);
        end
        send_byte(8'h02);
        send_word(32'h3C010010);
        checks++;
        if (imem_we !== 1'b1 || imem_addr !== 6'd0 || imem_di !== 32'h3C010010) begin
            errors++;
            $display("FAIL two_wr0 got we=%b addr=%0d di=%h req 1 0 3c010010", imem_we, imem_addr, imem_di);
        end
        send_word(32'h20020005);
        rx_valid = 1'b0;
        checks++;
        if (imem_we !== 1'b1 || imem_addr !== 6'd1 || imem_di !== 32'h20020005 || cpu_resetM !== 1'b0) begin
            errors++;
            $display("FAIL two_wr1 got we=%b addr=%0d di=%h cpu=%b req 1 1 20020005 0", imem_we, imem_addr, imem_di, cpu_resetM);
        end
        tick();
        checks++;
        if (cpu_resetM !== 1'b1 || done !== 1'b1 || words_loaded !== 7'd2 || rx_ready !== 1'b0) begin
            errors++;
            $display("FAIL two_run got cpu=%b done=%b wl=%0d rdy=%b req 1 1 2 0", cpu_resetM, done, words_loaded, rx_ready);
        end
        checks++;
        if (wr_cnt - w0 != 2 || xfer_cnt - x0 != 9) begin
            errors++;
            $display("FAIL two_counts got writes=%0d xfers=%0d req 2 9", wr_cnt - w0, xfer_cnt - x0);
        end
        checks++;
        if (mem[0] !== 32'h3C010010 || mem[1] !== 32'h20020005) begin
            errors++;
            $display("FAIL two_mem got %h %h req 3c010010 20020005", mem[0], mem[1]);
        end
        $display("TXN  two-word load");
    endtask

    task automatic test_bad_header();
        logic [7:0] hdr [2];
        int w0;
        hdr[0] = 8'h00;
        hdr[1] = 8'h41;
        for (int k = 0; k < 2; k++) begin
            w0 = wr_cnt;
            pulse_start();
            checks++;
            if (cpu_resetM !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL bad_start got cpu=%b done=%b req 0 0", cpu_resetM, done);
            end
            send_byte(hdr[k]);
            rx_valid = 1'b0;
            repeat (2) tick();
            checks++;
            if (error !== 1'b1 || cpu_resetM !== 1'b0 || busy !== 1'b0 || wr_cnt != w0) begin
                errors++;
                $display("FAIL bad_hdr_%02h got err=%b cpu=%b busy=%b writes=%0d req 1 0 0 0", hdr[k], error, cpu_resetM, busy, wr_cnt - w0);
            end
            $display("TXN  bad header %02h", hdr[k]);
        end
    endtask

    task automatic test_timeout();
        int w0;
        pulse_start();
        checks++;
        if (error !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL to_start got err=%b busy=%b req 0 1", error, busy);
        end
        send_byte(8'h01);
        send_byte(8'hAA);
        send_byte(8'hBB);
        rx_valid = 1'b0;
        w0 = wr_cnt;
        repeat (T - 1) tick();
        checks++;
        if (error !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL to_early got err=%b busy=%b req 0 1", error, busy);
        end
        tick();
        checks++;
        if (error !== 1'b1 || cpu_resetM !== 1'b0 || wr_cnt != w0) begin
            errors++;
            $display("FAIL to_fire got err=%b cpu=%b writes=%0d req 1 0 0", error, cpu_resetM, wr_cnt - w0);
        end
        $display("TXN  timeout");
        pulse_start();
        send_byte(8'h01);
        send_word(32'h12345678);
        rx_valid = 1'b0;
        tick();
        checks++;
        if (done !== 1'b1 || error !== 1'b0 || mem[0] !== 32'h12345678 || words_loaded !== 7'd1) begin
            errors++;
            $display("FAIL to_recover got done=%b err=%b mem0=%h wl=%0d req 1 0 12345678 1", done, error, mem[0], words_loaded);
        end
        $display("TXN  reload after timeout");
    endtask

    task automatic test_timeout_edge();
        pulse_start();
        send_byte(8'h01);
        rx_valid = 1'b0;
        repeat (T - 1) tick();
        send_byte(8'hC0);
        rx_valid = 1'b0;
        checks++;
        if (error !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL to_edge got err=%b busy=%b req 0 1", error, busy);
        end
        send_byte(8'hC1);
        send_byte(8'hC2);
        send_byte(8'hC3);
        rx_valid = 1'b0;
        tick();
        checks++;
        if (done !== 1'b1 || mem[0] !== 32'hC0C1C2C3) begin
            errors++;
            $display("FAIL to_edge_load got done=%b mem0=%h req 1 c0c1c2c3", done, mem[0]);
        end
        $display("TXN  byte at timeout limit");
    endtask

    task automatic test_backpressure();
        logic [31:0] w [3];
        int x0;
        w[0] = 32'hDEADBEEF;
        w[1] = 32'h01234567;
        w[2] = 32'h89ABCDEF;
        pulse_start();
        x0 = xfer_cnt;
        send_byte(8'h03);
        for (int i = 0; i < 3; i++) begin
            for (int b = 3; b >= 0; b--) begin
                rx_valid = 1'b0;
                rx_byte  = 8'($urandom);
                repeat ($urandom_range(0, 3)) tick();
                send_byte(w[i][b*8 +: 8]);
            end
        end
        rx_valid = 1'b0;
        tick();
        checks++;
        if (done !== 1'b1 || words_loaded !== 7'd3 || imem_addr !== 6'd2 || xfer_cnt - x0 != 13) begin
            errors++;
            $display("FAIL bp_end got done=%b wl=%0d addr=%0d xfers=%0d req 1 3 2 13", done, words_loaded, imem_addr, xfer_cnt - x0);
        end
        checks++;
        if (mem[0] !== w[0] || mem[1] !== w[1] || mem[2] !== w[2]) begin
            errors++;
            $display("FAIL bp_mem got %h %h %h req %h %h %h", mem[0], mem[1], mem[2], w[0], w[1], w[2]);
        end
        x0 = xfer_cnt;
        rx_byte  = 8'h99;
        rx_valid = 1'b1;
        repeat (3) tick();
        rx_valid = 1'b0;
        checks++;
        if (xfer_cnt != x0 || rx_ready !== 1'b0 || done !== 1'b1) begin
            errors++;
            $display("FAIL bp_extra got xfers=%0d rdy=%b done=%b req 0 0 1", xfer_cnt - x0, rx_ready, done);
        end
        $display("TXN  backpressure load");
    endtask

    task automatic test_full_load();
        pulse_start();
        send_byte(8'h40);
        for (int i = 0; i < 64; i++) send_word(word_of(i));
        rx_valid = 1'b0;
        checks++;
        if (imem_we !== 1'b1 || imem_addr !== 6'd63 || imem_di !== word_of(63)) begin
            errors++;
            $display("FAIL full_last got we=%b addr=%0d di=%h req 1 63 %h", imem_we, imem_addr, imem_di, word_of(63));
        end
        tick();
        checks++;
        if (done !== 1'b1 || words_loaded !== 7'd64 || imem_addr !== 6'd63 || cpu_resetM !== 1'b1) begin
            errors++;
            $display("FAIL full_end got done=%b wl=%0d addr=%0d cpu=%b req 1 64 63 1", done, words_loaded, imem_addr, cpu_resetM);
        end
        checks++;
        if (mem[0] !== word_of(0) || mem[31] !== word_of(31) || mem[63] !== word_of(63)) begin
            errors++;
            $display("FAIL full_mem got %h %h %h req %h %h %h", mem[0], mem[31], mem[63], word_of(0), word_of(31), word_of(63));
        end
        $display("TXN  64-word load");
    endtask

    task automatic test_reset_midload();
        pulse_start();
        send_byte(8'h02);
        send_word(32'h11223344);
        send_byte(8'h55);
        rx_valid = 1'b0;
        reset = 1'b0;
        tick();
        checks++;
        if ({rx_ready, imem_we, imem_addr, imem_di, cpu_resetM, busy, done, error, words_loaded} !== 51'd0) begin
            errors++;
            $display("FAIL mid_reset got rdy=%b we=%b addr=%0d di=%h cpu=%b busy=%b done=%b err=%b wl=%0d req all 0", rx_ready, imem_we, imem_addr, imem_di, cpu_resetM, busy, done, error, words_loaded);
        end
        checks++;
        if (mem[0] !== 32'h11223344) begin
            errors++;
            $display("FAIL mid_mem got %h req 11223344", mem[0]);
        end
        reset = 1'b1;
        repeat (2) tick();
        checks++;
        if (rx_ready !== 1'b0 || cpu_resetM !== 1'b0) begin
            errors++;
            $display("FAIL mid_after got rdy=%b cpu=%b req 0 0", rx_ready, cpu_resetM);
        end
        $display("TXN  reset mid-load");
    endtask

    initial begin
        test_reset();
        test_two_word();
        test_bad_header();
        test_timeout();
        test_timeout_edge();
        test_backpressure();
        test_full_load();
        test_reset_midload();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
